// File: rtl/formation_ctrl_if.sv
// Control/status bundle between the frame timing chain, game logic and the
// invader formation controller.
interface formation_ctrl_if;
  logic        vsync;
  logic        start;
  logic        clear;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        enabled;
  logic        dir;
  logic        landed;

  modport master (
    output vsync, start, clear, hit,
    input  xpos, ypos, enabled, dir, landed
  );

  modport slave (
    input  vsync, start, clear, hit,
    output xpos, ypos, enabled, dir, landed
  );
endinterface

// File: rtl/formation_ctrl.sv
// Invader formation motion controller: steps the formation once every period
// frames, reverses and drops a row at screen edges, flags landing at Y_MAX.
// Optional FORMATION_SPEEDUP_EN: each hit shortens the step period by one frame.
module formation_ctrl #(
  parameter int X_START   = 64,
  parameter int Y_START   = 32,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 736,
  parameter int Y_MAX     = 568,
  parameter int STEP_X    = 8,
  parameter int STEP_Y    = 16,
  parameter int FRAME_DIV = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  formation_ctrl_if.slave  bus
);

  localparam logic [11:0] X_START12  = 12'(X_START);
  localparam logic [11:0] Y_START12  = 12'(Y_START);
  localparam logic [12:0] X_MIN13    = 13'(X_MIN);
  localparam logic [12:0] X_MAX13    = 13'(X_MAX);
  localparam logic [12:0] Y_MAX13    = 13'(Y_MAX);
  localparam logic [12:0] STEP_X13   = 13'(STEP_X);
  localparam logic [12:0] STEP_Y13   = 13'(STEP_Y);
  localparam logic [7:0]  FRAME_DIV8 = 8'(FRAME_DIV);

  typedef enum logic [1:0] {IDLE, MOVE, DROP, DONE} state_t;

  state_t      state_q, state_d;
  logic        vsync_q;
  logic        tick;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        dir_q, dir_d;
  logic        enabled_q, enabled_d;
  logic        landed_q, landed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  per_q, per_d;
  logic [12:0] x_right13;
  logic [12:0] y_next13;

  // vsync_q resets high so a vsync already high at reset release is not a tick.
  assign tick      = bus.vsync & ~vsync_q;
  assign x_right13 = {1'b0, xpos_q} + STEP_X13;
  assign y_next13  = {1'b0, ypos_q} + STEP_Y13;

`ifdef FORMATION_SPEEDUP_EN
  logic [7:0] per_dec;
  assign per_dec = (per_q > 8'd1) ? (per_q - 8'd1) : 8'd1;
`else
  logic unused_hit;
  assign unused_hit = bus.hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b1;
      xpos_q    <= X_START12;
      ypos_q    <= Y_START12;
      dir_q     <= 1'b1;
      enabled_q <= 1'b0;
      landed_q  <= 1'b0;
      cnt_q     <= 8'd0;
      per_q     <= FRAME_DIV8;
    end else begin
      state_q   <= state_d;
      vsync_q   <= bus.vsync;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      dir_q     <= dir_d;
      enabled_q <= enabled_d;
      landed_q  <= landed_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    dir_d     = dir_q;
    enabled_d = enabled_q;
    landed_d  = landed_q;
    cnt_d     = cnt_q;
    per_d     = per_q;

    if (bus.clear) begin
      state_d   = IDLE;
      enabled_d = 1'b0;
      landed_d  = 1'b0;
    end else if (bus.start && (state_q == IDLE || state_q == DONE)) begin
      state_d   = MOVE;
      xpos_d    = X_START12;
      ypos_d    = Y_START12;
      dir_d     = 1'b1;
      enabled_d = 1'b1;
      landed_d  = 1'b0;
      cnt_d     = 8'd0;
      per_d     = FRAME_DIV8;
    end else if (tick && state_q == MOVE) begin
      if (cnt_q >= per_q - 8'd1) begin
        cnt_d = 8'd0;
        if (dir_q) begin
          if (x_right13 > X_MAX13) begin
            dir_d   = 1'b0;
            state_d = DROP;
          end else begin
            xpos_d = x_right13[11:0];
          end
        end else begin
          // Compare against X_MIN+STEP_X so the subtraction can never underflow.
          if ({1'b0, xpos_q} < X_MIN13 + STEP_X13) begin
            dir_d   = 1'b1;
            state_d = DROP;
          end else begin
            xpos_d = xpos_q - STEP_X13[11:0];
          end
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (tick && state_q == DROP) begin
      ypos_d = y_next13[11:0];
      cnt_d  = 8'd0;
      if (y_next13 >= Y_MAX13) begin
        state_d  = DONE;
        landed_d = 1'b1;
      end else begin
        state_d = MOVE;
      end
    end
`ifdef FORMATION_SPEEDUP_EN
    else if (bus.hit && (state_q == MOVE || state_q == DROP)) begin
      per_d = per_dec;
      if (cnt_q > per_dec - 8'd1) begin
        cnt_d = per_dec - 8'd1;
      end
    end
`endif
  end

  assign bus.xpos    = xpos_q;
  assign bus.ypos    = ypos_q;
  assign bus.enabled = enabled_q;
  assign bus.dir     = dir_q;
  assign bus.landed  = landed_q;

endmodule
